// File: rtl/types_pkg.sv
// Shared types for the data-memory controller and the load/store queue.
package types_pkg;

  // One retired LSQ entry as handed to the data-memory controller.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] ps2_data;
    logic [6:0]  pd;
    logic [4:0]  rob_tag;
    logic        store;
    logic        sw_sh_signal;
    logic        valid_data;
  } lsq_entry_t;

  // Access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } dmem_state_t;

  // Size encoding carried in sw_sh_signal: stores sw/sh, loads lw/lbu.
  localparam logic SZ_WORD      = 1'b0;
  localparam logic SZ_HALF_BYTE = 1'b1;

endpackage

// File: rtl/dmem_fifo.sv
// Small synchronous FIFO holding retired entries ahead of the access FSM.
// A push into a full FIFO is ignored; a pop in the same cycle does not help.
module dmem_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = buf_q[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) buf_q[wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: buffers retired LSQ entries and executes them in
// order against a word-organised, byte-addressed little-endian memory.
module dmem_ctrl
  import types_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        store_wb,
  input  lsq_entry_t  lsq_in,
  output logic        dmem_full,
  output logic        wb_valid,
  output logic [6:0]  wb_pd,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rob_tag,
  output logic        st_done,
  output logic [4:0]  st_rob_tag,
  output logic        drop_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = $bits(lsq_entry_t);

  dmem_state_t       state;
  dmem_state_t       state_nxt;
  lsq_entry_t        cur;
  lsq_entry_t        head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PW:0]       fifo_count;

  logic [31:0]       mem [MEM_WORDS];
  logic [31:0]       rd_word;
  logic [31:0]       ld_data;
  logic [31:0]       wr_data;
  logic [3:0]        byte_en;
  logic [AW-1:0]     word_idx;
  logic              mem_we;
  logic              rd_en;
  logic              unused_bits;

  assign fifo_push = store_wb && lsq_in.valid_data;
  assign dmem_full = fifo_full;
  assign word_idx  = cur.addr[AW+1:2];
  assign unused_bits = ^{cur.addr[31:AW+2], cur.valid_data, fifo_count};

  dmem_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (lsq_in),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head)
  );

  // Store lane steering: sw writes the whole word, sh the halfword at addr[1].
  always_comb begin
    byte_en = 4'b1111;
    wr_data = cur.ps2_data;
    if (cur.sw_sh_signal == SZ_HALF_BYTE) begin
      byte_en = cur.addr[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{cur.ps2_data[15:0]}};
    end
  end

  // Load result: full word for lw, zero-extended selected byte for lbu.
  always_comb begin
    ld_data = rd_word;
    if (cur.sw_sh_signal == SZ_HALF_BYTE)
      ld_data = {24'h0, rd_word[{cur.addr[1:0], 3'b000} +: 8]};
  end

  // Next-state and pulse outputs; the IDLE state is visited between accesses.
  always_comb begin
    state_nxt  = state;
    fifo_pop   = 1'b0;
    mem_we     = 1'b0;
    rd_en      = 1'b0;
    st_done    = 1'b0;
    st_rob_tag = '0;
    wb_valid   = 1'b0;
    wb_pd      = '0;
    wb_rob_tag = '0;
    wb_data    = '0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cur.store) begin
          mem_we     = 1'b1;
          st_done    = !reset;
          st_rob_tag = reset ? 5'd0 : cur.rob_tag;
          state_nxt  = ST_IDLE;
        end else begin
          rd_en     = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        wb_valid   = 1'b1;
        wb_pd      = cur.pd;
        wb_rob_tag = cur.rob_tag;
        wb_data    = ld_data;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, current entry, registered read word and sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cur      <= '0;
      rd_word  <= '0;
      drop_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fifo_pop)             cur      <= head;
      if (rd_en)                rd_word  <= mem[word_idx];
      if (store_wb && fifo_full) drop_err <= 1'b1;
    end
  end

  // Byte-enabled memory write; a store caught by reset is abandoned.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus randomized bursts checked
// against a word-array reference model and an expected-completion queue.
module tb_dmem_ctrl;
  import types_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        store_wb = 1'b0;
  lsq_entry_t  lsq_in = '0;
  logic        dmem_full, wb_valid, st_done, drop_err;
  logic [6:0]  wb_pd;
  logic [31:0] wb_data;
  logic [4:0]  wb_rob_tag, st_rob_tag;

  always #5 clk = ~clk;

  dmem_ctrl #(.FIFO_DEPTH(4), .MEM_WORDS(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .store_wb   (store_wb),
    .lsq_in     (lsq_in),
    .dmem_full  (dmem_full),
    .wb_valid   (wb_valid),
    .wb_pd      (wb_pd),
    .wb_data    (wb_data),
    .wb_rob_tag (wb_rob_tag),
    .st_done    (st_done),
    .st_rob_tag (st_rob_tag),
    .drop_err   (drop_err)
  );

  typedef struct {
    bit          is_load;
    logic [4:0]  tag;
    logic [6:0]  pd;
    logic [31:0] data;
  } comp_t;

  comp_t       exp_q[$];
  comp_t       obs_q[$];
  comp_t       mon_c;
  logic [31:0] ref_mem [256];
  logic [31:0] seen_data[$];
  int          tests = 0;
  int          fails = 0;

  // Completion monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset && (st_done || wb_valid)) begin
      mon_c.is_load = wb_valid;
      mon_c.tag     = wb_valid ? wb_rob_tag : st_rob_tag;
      mon_c.pd      = wb_pd;
      mon_c.data    = wb_data;
      obs_q.push_back(mon_c);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic lsq_entry_t mk(input bit st, input bit sz, input logic [31:0] addr,
                                    input logic [31:0] data, input logic [6:0] pd,
                                    input logic [4:0] tag);
    lsq_entry_t e;
    e.addr = addr; e.ps2_data = data; e.pd = pd; e.rob_tag = tag;
    e.store = st; e.sw_sh_signal = sz; e.valid_data = 1'b1;
    return e;
  endfunction

  task automatic preload(input int idx, input logic [31:0] v);
    dut.mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  // Reference behaviour: apply an entry to the word array, queue its completion.
  task automatic model_push(input lsq_entry_t e);
    comp_t c;
    int unsigned idx, lane;
    logic [31:0] w;
    if (!e.valid_data) return;
    idx  = (e.addr / 4) % 256;
    lane = e.addr % 4;
    w    = ref_mem[idx];
    c.is_load = !e.store; c.tag = e.rob_tag; c.pd = e.pd; c.data = 0;
    if (e.store) begin
      if (!e.sw_sh_signal) w = e.ps2_data;
      else if (lane >= 2) w = (w & 32'h0000FFFF) | ((e.ps2_data & 32'hFFFF) << 16);
      else                w = (w & 32'hFFFF0000) | (e.ps2_data & 32'hFFFF);
      ref_mem[idx] = w;
    end else begin
      c.data = e.sw_sh_signal ? ((w >> (8 * lane)) & 32'hFF) : w;
    end
    exp_q.push_back(c);
  endtask

  task automatic send(input lsq_entry_t e);
    @(negedge clk);
    store_wb = 1'b1;
    lsq_in   = e;
    @(posedge clk);
    #1;
    store_wb = 1'b0;
    lsq_in   = '0;
  endtask

  task automatic op(input lsq_entry_t e);
    model_push(e);
    send(e);
  endtask

  // Wait (bounded) for all expected completions, then compare in order.
  task automatic drain(input string tag);
    comp_t e, o;
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    seen_data.delete();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_kind"}, 32'(o.is_load), 32'(e.is_load));
      chk({tag, "_tag"}, 32'(o.tag), 32'(e.tag));
      if (e.is_load) begin
        chk({tag, "_pd"}, 32'(o.pd), 32'(e.pd));
        chk({tag, "_data"}, o.data, e.data);
        seen_data.push_back(o.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 0);
    chk({tag, "_wb_pd"}, 32'(wb_pd), 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_wb_tag"}, 32'(wb_rob_tag), 0);
    chk({tag, "_st_done"}, 32'(st_done), 0);
    chk({tag, "_st_tag"}, 32'(st_rob_tag), 0);
    chk({tag, "_full"}, 32'(dmem_full), 0);
    chk({tag, "_drop"}, 32'(drop_err), 0);
    chk({tag, "_count"}, 32'(dut.fifo_count), 0);
  endtask

  initial begin
    lsq_entry_t  e;
    logic [31:0] lbu_exp [4];
    logic [31:0] v;

    for (int i = 0; i < 256; i++) preload(i, $urandom);
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // sw then lw with exact latency checks
    e = mk(1'b1, SZ_WORD, 32'h10, 32'hDEADBEEF, 7'd0, 5'd1);
    op(e);
    @(negedge clk); chk("sw_lat_early", 32'(st_done), 0);
    @(negedge clk); chk("sw_lat", 32'(st_done), 1);
    chk("sw_lat_tag", 32'(st_rob_tag), 1);
    @(negedge clk); chk("sw_one_pulse", 32'(st_done), 0);
    drain("sw");
    e = mk(1'b0, SZ_WORD, 32'h10, 32'h0, 7'd5, 5'd2);
    op(e);
    @(negedge clk); chk("lw_lat_early1", 32'(wb_valid), 0);
    @(negedge clk); chk("lw_lat_early2", 32'(wb_valid), 0);
    @(negedge clk); chk("lw_lat", 32'(wb_valid), 1);
    chk("lw_lat_pd", 32'(wb_pd), 5);
    chk("lw_lat_data", wb_data, 32'hDEADBEEF);
    @(negedge clk); chk("lw_one_pulse", 32'(wb_valid), 0);
    drain("lw");

    // sh byte lanes
    preload(8, 32'h11223344);
    op(mk(1'b1, SZ_HALF_BYTE, 32'h22, 32'h0000ABCD, 7'd0, 5'd3));
    op(mk(1'b0, SZ_WORD, 32'h20, 32'h0, 7'd6, 5'd4));
    drain("sh");
    chk("sh_word_mem", dut.mem[8], 32'hABCD3344);
    chk("sh_word_ld", (seen_data.size() > 0) ? seen_data[0] : 32'hX, 32'hABCD3344);

    // lbu lanes, back-to-back
    preload(12, 32'h80FF7F01);
    lbu_exp[0] = 32'h01; lbu_exp[1] = 32'h7F; lbu_exp[2] = 32'hFF; lbu_exp[3] = 32'h80;
    for (int i = 0; i < 4; i++)
      op(mk(1'b0, SZ_HALF_BYTE, 32'h30 + 32'(i), 32'h0, 7'(8 + i), 5'(5 + i)));
    drain("lbu");
    for (int i = 0; i < 4; i++)
      chk($sformatf("lbu_lane%0d", i), (seen_data.size() > i) ? seen_data[i] : 32'hX, lbu_exp[i]);

    // address wrap
    v = $urandom;
    op(mk(1'b1, SZ_WORD, 32'h400, v, 7'd0, 5'd9));
    op(mk(1'b0, SZ_WORD, 32'h0, 32'h0, 7'd11, 5'd10));
    drain("wrap");
    chk("wrap_mem0", dut.mem[0], v);
    chk("wrap_ld", (seen_data.size() > 0) ? seen_data[0] : 32'hX, v);

    // Overflow: seven back-to-back lw from an empty FIFO. With one load
    // serviced every 3 cycles, occupancy after each pulse is 1,1,2,3,3,4 so
    // the 7th pulse meets a full FIFO and is dropped.
    chk("ovf_pre_drop", 32'(drop_err), 0);
    for (int i = 0; i < 7; i++) begin
      e = mk(1'b0, SZ_WORD, 32'(4 * (40 + i)), 32'h0, 7'(20 + i), 5'(12 + i));
      if (i < 6) model_push(e);
      send(e);
      if (i == 4) chk("ovf_not_full", 32'(dmem_full), 0);
      if (i == 5) begin
        chk("ovf_full", 32'(dmem_full), 1);
        chk("ovf_no_drop_yet", 32'(drop_err), 0);
      end
      if (i == 6) begin
        chk("ovf_full_held", 32'(dmem_full), 1);
        chk("ovf_drop", 32'(drop_err), 1);
      end
    end
    drain("ovf");
    chk("ovf_drop_sticky", 32'(drop_err), 1);

    // Reset during a load's ACCESS with another load still queued
    send(mk(1'b0, SZ_WORD, 32'h44, 32'h0, 7'd30, 5'd20));
    send(mk(1'b0, SZ_WORD, 32'h48, 32'h0, 7'd31, 5'd21));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("rst_load");
    @(negedge clk);
    reset = 1'b0;
    drain("rst_load");

    // Reset during a store's ACCESS: the write must not land
    preload(20, 32'hCAFEF00D);
    send(mk(1'b1, SZ_WORD, 32'h50, 32'h12345678, 7'd0, 5'd22));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("rst_store");
    @(negedge clk);
    reset = 1'b0;
    drain("rst_store");
    op(mk(1'b0, SZ_WORD, 32'h50, 32'h0, 7'd32, 5'd23));
    drain("rst_store_ld");
    chk("rst_store_kept", dut.mem[20], 32'hCAFEF00D);

    // Store after reset completes normally
    op(mk(1'b1, SZ_WORD, 32'h54, 32'h0BADC0DE, 7'd0, 5'd24));
    op(mk(1'b0, SZ_WORD, 32'h54, 32'h0, 7'd33, 5'd25));
    drain("post_rst");

    // Randomized short bursts (at most 3 back-to-back, never overflowing)
    for (int g = 0; g < 25; g++) begin
      int n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        e.addr         = $urandom;
        if ($urandom_range(0, 1) == 1) e.addr = 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
        e.ps2_data     = $urandom;
        e.pd           = 7'($urandom_range(0, 127));
        e.rob_tag      = 5'($urandom_range(0, 31));
        e.store        = 1'($urandom_range(0, 1));
        e.sw_sh_signal = 1'($urandom_range(0, 1));
        e.valid_data   = ($urandom_range(0, 7) != 0);
        op(e);
      end
      drain("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller directly downstream of the load/store queue. It accepts retired LSQ entries, pulled one per `store_wb` pulse, into a small in-order FIFO. It executes each entry against an internal word-organised, byte-addressed data memory: sw/sh writes, and lw/lbu reads whose results are written back to the PRF. It returns `dmem_full` to the LSQ so the LSQ can gate retirement.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: retired-entry buffer depth; must be a power of 2.
- `MEM_WORDS`, 256: data-memory size in 32-bit words.

Ports:
- `clk`, input, 1: single clock, rising-edge.
- `reset`, input, 1: synchronous, active-high.
- `store_wb`, input, 1: LSQ retire pulse; `lsq_in` is valid in this cycle.
- `lsq_in`, input, `lsq_entry_t`: retired entry with fields addr[31:0], ps2_data[31:0], pd[6:0], rob_tag[4:0], store, sw_sh_signal, valid_data.
- `dmem_full`, output, 1: FIFO holds FIFO_DEPTH entries.
- `wb_valid`, output, 1: one-cycle load writeback pulse.
- `wb_pd`, output, 7: destination physical register.
- `wb_data`, output, 32: load result.
- `wb_rob_tag`, output, 5: ROB tag of the completed load.
- `st_done`, output, 1: one-cycle pulse when a store has written memory.
- `st_rob_tag`, output, 5: ROB tag of the completed store.
- `drop_err`, output, 1: sticky flag; set when a `store_wb` arrives while the FIFO is full.

## Operation
- Size encoding in `sw_sh_signal`:
  - Stores: 0 = sw, 1 = sh.
  - Loads: 0 = lw, 1 = lbu.
- FIFO push:
  - A push occurs on `store_wb && !dmem_full`. Entries with `valid_data` = 0 are ignored and are not pushed.
  - On `store_wb && dmem_full`, the entry is dropped and `drop_err` is set. `drop_err` is cleared only by reset.
  - A pop in the same cycle does not free room for that cycle's push; fullness is judged from the pre-edge count.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the `cur` register and go to ACCESS.
  - ACCESS, store: perform the write at this edge and pulse `st_done` with `st_rob_tag` = cur.rob_tag. Go to IDLE.
  - ACCESS, load: register the word read (the memory has synchronous read) and go to RESP.
  - RESP: drive `wb_valid`, `wb_pd`, `wb_rob_tag` and `wb_data` for one cycle, then go to IDLE.
- Addressing:
  - Word index = addr[log2(MEM_WORDS)+1:2]; upper bits are ignored, so accesses wrap modulo the memory size.
  - Layout is little-endian.
- Store semantics:
  - sw ignores addr[1:0] and writes all 4 bytes.
  - sh writes ps2_data[15:0] to the halfword selected by addr[1] (byte enable 0011 or 1100). addr[0] is ignored.
- Load semantics:
  - lw ignores addr[1:0] and returns the full word.
  - lbu returns the byte selected by addr[1:0], zero-extended to 32 bits.
- Byte-enable writes are per-byte; unselected bytes are preserved.
- Ordering is strictly FIFO. A load following a store to the same address observes the stored value, because the store has already written memory before the load's ACCESS cycle.

## Timing
- Reset values:
  - All outputs are 0.
  - FIFO pointers and count are 0; FSM is IDLE; `cur` is 0.
  - Memory contents are NOT reset; the bench preloads them hierarchically.
- Reset asserted mid-operation flushes the FIFO and any in-flight access. No `wb_valid` or `st_done` pulse occurs in the cycle after reset is asserted. A store already in ACCESS at the reset edge is not performed.
- Latency, counted from `store_wb` at edge N into an empty FIFO with the FSM in IDLE:
  - The push is visible at N+1.
  - The pop occurs at edge N+1, putting the FSM in ACCESS.
  - Store: the write occurs and `st_done` is high in the cycle after edge N+1, i.e. the store completes 2 cycles after `store_wb`.
  - Load: `wb_valid` is high 3 cycles after `store_wb`.
- Throughput: one store per 2 cycles and one load per 3 cycles (the IDLE state is always visited).
- `dmem_full` is combinational from the count.

## Structure
- Add to `types_pkg`:
  - `lsq_entry_t` (the packed entry struct above, shared with the LSQ).
  - `dmem_state_t` enum.
  - Localparams `SZ_WORD` = 0, `SZ_HALF_BYTE` = 1.
- One sub-module, `dmem_fifo`: a parameterised synchronous FIFO with push, pop, full, empty, count and head. It is instantiated once.
- The memory array, byte-lane logic and FSM live in `dmem_ctrl` itself.

## Test plan
- sw then lw: sw addr 0x10, data 0xDEADBEEF, then lw addr 0x10 with pd = 5 -> `st_done` pulses once; then `wb_valid`, `wb_pd` = 5, `wb_data` = 0xDEADBEEF.
- sh byte lanes: word 0x20 preloaded with 0x11223344; sh addr 0x22, data 0x0000ABCD -> word becomes 0xABCD3344; lw returns 0xABCD3344.
- lbu lanes: word 0x30 = 0x80FF7F01; lbu at 0x30, 0x31, 0x32 and 0x33 -> 0x01, 0x7F, 0xFF, 0x80, all zero-extended (e.g. 0x000000FF).
- Back-to-back overflow: 5 consecutive `store_wb` pulses while the FSM is busy -> `dmem_full` = 1 after the 4th accepted entry, `drop_err` = 1, and exactly 4 completions occur in FIFO order of rob_tag.
- Address wrap: MEM_WORDS = 256; sw addr 0x400 -> word index 0 is written; lw addr 0x0 returns the same data.
- Reset mid-load: assert reset while in RESP-pending ACCESS -> no `wb_valid`, all outputs 0, count 0; a subsequent store completes normally.
